decryption_controller: RTL
==========================

// Module: decryption_controller
// PURPOSE
//  Ascon-128 authenticated decryption engine; counterpart of the encryption controller in the same datapath.
//  Takes IV, key, nonce, 256-bit AD, 256-bit ciphertext and 128-bit received tag.
//  Recovers the 256-bit plaintext and flags whether the recomputed tag matches the received tag.
//  Contains its own Ascon permutation, one round per clock, so it needs no external permutation handshake.
// PARAMETERS
//  PA_ROUNDS  12  rounds for init and finalization (p^a)
//  PB_ROUNDS   6  rounds per AD or ciphertext block (p^b)
// PORTS
//  clk               in   1    clock, rising edge
//  rst               in   1    synchronous reset, active-high
//  IV                in   64   Ascon IV (0x80400c0600000000 for Ascon-128)
//  key               in   128  secret key K
//  nonce             in   128  nonce N
//  associated_data   in   256  AD; [255:192] is block 0
//  cipher_text       in   256  ciphertext; [255:192] is block 0
//  tag               in   128  received tag
//  decryption_start  in   1    start request, level-sampled
//  S                 out  320  current state; x0 = S[319:256]
//  plain_text        out  256  recovered plaintext
//  tag_valid         out  1    1 = recomputed tag equals tag input
//  decryption_ready  out  1    one-cycle done pulse
//  busy              out  1    1 from the cycle after start until done
// BEHAVIOUR
//  - Reset: S, plain_text, tag_valid, decryption_ready and busy all 0; all internal registers 0; FSM goes to IDLE.
//  - Start acceptance: decryption_start is accepted only in IDLE.
//    - In any other state, including DONE, it is ignored.
//    - On acceptance: key, cipher_text, associated_data and tag are latched; later input changes have no effect.
//    - On acceptance: S <= {IV, key, nonce}; plain_text and tag_valid are cleared to 0.
//  - FSM states: IDLE -> INIT -> AD -> CT -> FINAL -> CHECK -> DONE -> IDLE.
//  - Each permutation round, for round index i, uses constant c = {~i[3:0], i[3:0]} on x2:
//    - INIT and FINAL use i = 0..11.
//    - p^b uses i = 12-PB_ROUNDS .. 11.
//  - INIT: PA_ROUNDS rounds. In the last-round update, S[127:0] ^= key.
//  - AD: 5 blocks.
//    - Blocks 0-3 come from associated_data; block 4 is the padding block 64'h8000_0000_0000_0000.
//    - Each block is XORed into x0 on entry, followed by PB_ROUNDS rounds.
//    - After block 4, S[0] ^= 1 (domain separation).
//  - CT: 4 blocks, i = 0..3. On entry to each block:
//    - P_i = x0 ^ C_i, written to plain_text[255-64i -: 64].
//    - x0 <= C_i.
//    - Then PB_ROUNDS rounds.
//  - FINAL: on entry, x0 ^= 64'h8000_0000_0000_0000 (empty final block) and S[255:128] ^= key; then PA_ROUNDS rounds.
//  - CHECK: one cycle. tag_valid <= ((S[127:0] ^ key) == latched tag).
//  - DONE: one cycle. decryption_ready = 1, busy = 0.
//  - Latency: start sampled at edge N gives decryption_ready high in cycle N + 2 + 2*PA_ROUNDS + 9*PB_ROUNDS.
//    With defaults this is 80.
//  - Phase-boundary XORs are folded into the round register update; there are no idle cycles between phases.
//  - Output hold: plain_text, tag_valid and S keep their values after DONE until the next accepted start or reset.
//  - rst mid-operation: the FSM returns to IDLE on that edge, decryption_ready never pulses, and all outputs are 0.
//  - rst has priority over decryption_start in the same cycle.
// CONFIGURATION
//  - DEC_RELEASE_GATE_EN defined:
//    - plain_text is driven as (tag_valid ? plain_reg : 256'h0).
//    - plain_text is 0 while busy, and stays 0 on tag mismatch.
//  - DEC_RELEASE_GATE_EN undefined:
//    - plain_text shows plain_reg directly, including unverified plaintext during CT and after a mismatch.
// TESTING
//  - Round trip: IV=0x80400c0600000000, K=N=0x000102..0F, AD=0, PT=0x00..1F (bytes).
//    Encrypt with encryption controller -> decrypt gives plain_text==PT and tag_valid=1.
//  - Flip cipher_text[0] in the round-trip vector -> tag_valid=0.
//    plain_text bit 0 differs from PT; plain_text is all 0 if DEC_RELEASE_GATE_EN is defined.
//  - Flip tag[127] only -> tag_valid=0. With the gate off, plain_text==PT.
//  - Latency: assert decryption_start for one cycle at N -> busy=1 from N+1,
//    decryption_ready=1 only in cycle N+80, busy=0 in N+80.
//  - Hold decryption_start high throughout -> a new run starts only in the IDLE cycle after DONE (N+81).
//    Changing key at N+10 does not alter the result.
//  - Assert rst at cycle N+30 -> next cycle busy=0, S=0, plain_text=0, and no decryption_ready pulse.
//    A fresh start then completes normally.

Source files
------------

// File: rtl/decryption_controller_if.sv
// Bus bundle for decryption_controller: the request side (IV, key, nonce,
// AD, ciphertext, received tag, start) and the result side (state, plaintext,
// tag verdict, ready pulse, busy).
interface decryption_controller_if;
    logic [63:0]  IV;
    logic [127:0] key;
    logic [127:0] nonce;
    logic [255:0] associated_data;
    logic [255:0] cipher_text;
    logic [127:0] tag;
    logic         decryption_start;
    logic [319:0] S;
    logic [255:0] plain_text;
    logic         tag_valid;
    logic         decryption_ready;
    logic         busy;

    modport master (
        output IV, key, nonce, associated_data, cipher_text, tag, decryption_start,
        input  S, plain_text, tag_valid, decryption_ready, busy
    );

    modport slave (
        input  IV, key, nonce, associated_data, cipher_text, tag, decryption_start,
        output S, plain_text, tag_valid, decryption_ready, busy
    );
endinterface

// File: rtl/decryption_controller.sv
// Ascon-128 authenticated decryption engine with an internal one-round-per-clock
// permutation. Phase-boundary XORs are folded into the round update so phases
// run back to back. Optional macro DEC_RELEASE_GATE_EN: when defined, plaintext
// is only released once the recomputed tag has matched.
module decryption_controller #(
    parameter int unsigned PA_ROUNDS = 12,
    parameter int unsigned PB_ROUNDS = 6
) (
    input logic clk,
    input logic rst,
    decryption_controller_if.slave bus
);

    localparam logic [3:0]  PA_FIRST = 4'(12 - PA_ROUNDS);
    localparam logic [3:0]  PB_FIRST = 4'(12 - PB_ROUNDS);
    localparam logic [3:0]  LAST_RND = 4'd11;
    localparam logic [63:0] PAD      = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {IDLE, INIT, AD, CT, FINAL, CHECK, DONE} state_t;

    state_t           state_q, state_d;
    logic [319:0]     s_q, s_d;
    logic [3:0][63:0] plain_q, plain_d;
    logic             tag_valid_q, tag_valid_d;
    logic [127:0]     key_q, key_d;
    logic [127:0]     tag_q, tag_d;
    logic [3:0][63:0] ct_q, ct_d;
    logic [3:0][63:0] ad_q, ad_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [2:0]       blk_q, blk_d;

    logic [319:0]     round_in;
    logic [319:0]     round_out;
    logic [63:0]      ad_word;
    logic [63:0]      ct_word;

    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
        x2 = x2 ^ {56'h0, ~i, i};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Block 0 sits in the top word, so word index is 3 - block number.
    assign ad_word = (blk_q == 3'd4) ? PAD : ad_q[2'd3 - blk_q[1:0]];
    assign ct_word = ct_q[2'd3 - blk_q[1:0]];

    // Apply the block-entry XORs ahead of the first round of each block.
    always_comb begin
        round_in = s_q;
        case (state_q)
            AD: if (rnd_q == PB_FIRST) round_in[319:256] = s_q[319:256] ^ ad_word;
            CT: if (rnd_q == PB_FIRST) round_in[319:256] = ct_word;
            FINAL: if (rnd_q == PA_FIRST) begin
                round_in[319:256] = s_q[319:256] ^ PAD;
                round_in[255:128] = s_q[255:128] ^ key_q;
            end
            default: ;
        endcase
    end

    assign round_out = ascon_round(round_in, rnd_q);

    // Phase sequencing, round/block counters and post-round XORs.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        plain_d     = plain_q;
        tag_valid_d = tag_valid_q;
        key_d       = key_q;
        tag_d       = tag_q;
        ct_d        = ct_q;
        ad_d        = ad_q;
        rnd_d       = rnd_q;
        blk_d       = blk_q;
        case (state_q)
            IDLE: if (bus.decryption_start) begin
                key_d       = bus.key;
                tag_d       = bus.tag;
                ct_d        = bus.cipher_text;
                ad_d        = bus.associated_data;
                s_d         = {bus.IV, bus.key, bus.nonce};
                plain_d     = '0;
                tag_valid_d = 1'b0;
                rnd_d       = PA_FIRST;
                blk_d       = '0;
                state_d     = INIT;
            end
            INIT: begin
                s_d   = round_out;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) begin
                    s_d[127:0] = round_out[127:0] ^ key_q;
                    rnd_d      = PB_FIRST;
                    blk_d      = '0;
                    state_d    = AD;
                end
            end
            AD: begin
                s_d   = round_out;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) begin
                    rnd_d = PB_FIRST;
                    blk_d = blk_q + 3'd1;
                    if (blk_q == 3'd4) begin
                        s_d[0]  = ~round_out[0];
                        blk_d   = '0;
                        state_d = CT;
                    end
                end
            end
            CT: begin
                if (rnd_q == PB_FIRST) plain_d[2'd3 - blk_q[1:0]] = s_q[319:256] ^ ct_word;
                s_d   = round_out;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) begin
                    rnd_d = PB_FIRST;
                    blk_d = blk_q + 3'd1;
                    if (blk_q == 3'd3) begin
                        rnd_d   = PA_FIRST;
                        blk_d   = '0;
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                s_d   = round_out;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) state_d = CHECK;
            end
            CHECK: begin
                tag_valid_d = ((s_q[127:0] ^ key_q) == tag_q);
                state_d     = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset clearing every flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            plain_q     <= '0;
            tag_valid_q <= 1'b0;
            key_q       <= '0;
            tag_q       <= '0;
            ct_q        <= '0;
            ad_q        <= '0;
            rnd_q       <= '0;
            blk_q       <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            plain_q     <= plain_d;
            tag_valid_q <= tag_valid_d;
            key_q       <= key_d;
            tag_q       <= tag_d;
            ct_q        <= ct_d;
            ad_q        <= ad_d;
            rnd_q       <= rnd_d;
            blk_q       <= blk_d;
        end
    end

    assign bus.S                = s_q;
    assign bus.tag_valid        = tag_valid_q;
    assign bus.decryption_ready = (state_q == DONE);
    assign bus.busy             = (state_q != IDLE) && (state_q != DONE);
`ifdef DEC_RELEASE_GATE_EN
    assign bus.plain_text = tag_valid_q ? plain_q : '0;
`else
    assign bus.plain_text = plain_q;
`endif

endmodule
